// File: rtl/perf_counter_unit.sv
// perf_counter_unit: snoops cpu pc/read/write/halted and external strobes into counters,
// freezes on halt and serves multi-word counters from a snapshot shadow for atomic readout.
module perf_counter_unit #(
    parameter int PC_WIDTH   = 10,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int NUM_EXT    = 2,
    parameter int SATURATE   = 0,
    localparam int NUM_CNT   = 4 + NUM_EXT,
    localparam int WORDS     = (CNT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
    localparam int SEL_W     = $clog2(NUM_CNT),
    localparam int WRD_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int EXT_W     = (NUM_EXT > 0) ? NUM_EXT : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic                  halted_i,
    input  logic [EXT_W-1:0]      ext_evt_i,
    input  logic                  clr_i,
    input  logic                  snap_i,
    input  logic                  rd_en_i,
    input  logic [SEL_W-1:0]      rd_sel_i,
    input  logic [WRD_W-1:0]      rd_word_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_err_o,
    output logic                  frozen_o,
    output logic [NUM_CNT-1:0]    ovf_o
);
    localparam int PAD_W = WORDS * DATA_WIDTH;

    logic [CNT_WIDTH-1:0]  cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_CNT];
    logic [CNT_WIDTH-1:0]  shd_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]  shd_d [NUM_CNT];
    logic [NUM_CNT-1:0]    ovf_q, ovf_d, inc;
    logic [PC_WIDTH-1:0]   pc_prev_q, pc_prev_d;
    logic                  frozen_q, frozen_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_err_q, rd_err_d;
    logic                  sel_ok, word_ok;
    logic [SEL_W-1:0]      sel;
    logic [WRD_W-1:0]      wrd;
    logic [PAD_W-1:0]      pad;

    always_comb begin
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = pc_i != pc_prev_q;
        inc[2] = read_i;
        inc[3] = write_i;
        for (int k = 0; k < NUM_EXT; k++) inc[4+k] = ext_evt_i[k];
    end

    // clr dominates; a halt seen on an unfrozen edge snapshots instead of counting
    always_comb begin
        cnt_d     = cnt_q;
        shd_d     = shd_q;
        ovf_d     = ovf_q;
        frozen_d  = frozen_q;
        pc_prev_d = pc_prev_q;
        if (clr_i) begin
            for (int i = 0; i < NUM_CNT; i++) cnt_d[i] = '0;
            ovf_d     = '0;
            frozen_d  = 1'b0;
            pc_prev_d = '1;
        end else begin
            if (snap_i || (halted_i && !frozen_q)) shd_d = cnt_q;
            frozen_d = frozen_q | halted_i;
            if (!frozen_q && !halted_i) begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (inc[i]) begin
                        if (&cnt_q[i]) ovf_d[i] = 1'b1;
                        cnt_d[i] = (SATURATE != 0 && &cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
                    end
                end
                if (inc[1]) pc_prev_d = pc_i;
            end
        end
    end

    always_comb begin
        sel_ok    = 32'(rd_sel_i) < NUM_CNT;
        word_ok   = 32'(rd_word_i) < WORDS;
        sel       = sel_ok ? rd_sel_i : '0;
        wrd       = word_ok ? rd_word_i : '0;
        pad       = PAD_W'(shd_q[sel]);
        rd_err_d  = rd_en_i && !(sel_ok && word_ok);
        rd_data_d = !rd_en_i ? rd_data_q :
                    rd_err_d ? '0 : DATA_WIDTH'(pad >> (32'(wrd) * DATA_WIDTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
                shd_q[i] <= '0;
            end
            ovf_q      <= '0;
            frozen_q   <= 1'b0;
            pc_prev_q  <= '1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shd_q      <= shd_d;
            ovf_q      <= ovf_d;
            frozen_q   <= frozen_d;
            pc_prev_q  <= pc_prev_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en_i;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign frozen_o   = frozen_q;
    assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: three instances (32-bit wrap, 8-bit wrap, 8-bit saturate) share
// one random stimulus and are compared against an event-level counting model.
module tb_perf_counter_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] pc;
    logic read, write, halted, clr, snap, rd_en;
    logic [1:0] ext;
    logic [2:0] rd_sel;
    logic rd_word;
    logic [2:0][15:0] rd_data;
    logic [2:0] rd_valid, rd_err, frozen;
    logic [2:0][5:0] ovf;

    perf_counter_unit #(.CNT_WIDTH(32), .SATURATE(0)) u_main (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .read_i(read), .write_i(write), .halted_i(halted),
        .ext_evt_i(ext), .clr_i(clr), .snap_i(snap), .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_word_i(rd_word),
        .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]), .rd_err_o(rd_err[0]), .frozen_o(frozen[0]), .ovf_o(ovf[0]));
    perf_counter_unit #(.CNT_WIDTH(8), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .read_i(read), .write_i(write), .halted_i(halted),
        .ext_evt_i(ext), .clr_i(clr), .snap_i(snap), .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_word_i(rd_word),
        .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]), .rd_err_o(rd_err[1]), .frozen_o(frozen[1]), .ovf_o(ovf[1]));
    perf_counter_unit #(.CNT_WIDTH(8), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .read_i(read), .write_i(write), .halted_i(halted),
        .ext_evt_i(ext), .clr_i(clr), .snap_i(snap), .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_word_i(rd_word),
        .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]), .rd_err_o(rd_err[2]), .frozen_o(frozen[2]), .ovf_o(ovf[2]));

    int cw[3] = '{32, 8, 8};
    bit sat[3] = '{0, 0, 1};
    int nw[3] = '{2, 1, 1};
    longint cnt[3][6];
    longint shd[3][6];
    bit [5:0] m_ovf[3];
    bit m_frz[3];
    logic [9:0] m_pcp[3];
    bit e_valid[3], e_err[3];
    longint e_data[3];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void bump(int m, int i);
        longint mx = (64'd1 << cw[m]) - 1;
        if (cnt[m][i] == mx) begin
            m_ovf[m][i] = 1'b1;
            cnt[m][i] = sat[m] ? mx : 0;
        end else cnt[m][i]++;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 6; i++) begin
                cnt[m][i] = 0;
                shd[m][i] = 0;
            end
            m_ovf[m] = '0; m_frz[m] = 0; m_pcp[m] = '1;
            e_valid[m] = 0; e_err[m] = 0; e_data[m] = 0;
        end
    endfunction

    function automatic void take_snapshot(int m);
        for (int i = 0; i < 6; i++) shd[m][i] = cnt[m][i];
    endfunction

    function automatic void model_edge();
        for (int m = 0; m < 3; m++) begin
            e_valid[m] = rd_en;
            e_err[m] = rd_en && (rd_sel >= 6 || rd_word >= nw[m]);
            if (rd_en) e_data[m] = e_err[m] ? 0 : (shd[m][rd_sel] >> (16 * rd_word)) & 64'hFFFF;
            if (clr) begin
                for (int i = 0; i < 6; i++) cnt[m][i] = 0;
                m_ovf[m] = '0; m_frz[m] = 0; m_pcp[m] = '1;
            end else if (m_frz[m]) begin
                if (snap) take_snapshot(m);
            end else if (halted) begin
                take_snapshot(m);
                m_frz[m] = 1;
            end else begin
                if (snap) take_snapshot(m);
                bump(m, 0);
                if (pc != m_pcp[m]) begin
                    bump(m, 1);
                    m_pcp[m] = pc;
                end
                if (read) bump(m, 2);
                if (write) bump(m, 3);
                for (int k = 0; k < 2; k++) if (ext[k]) bump(m, 4 + k);
            end
        end
    endfunction

    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rd_valid[%0d]", m), 64'(rd_valid[m]), 64'(e_valid[m]));
            chk($sformatf("rd_data[%0d]", m), 64'(rd_data[m]), e_data[m]);
            if (e_valid[m]) chk($sformatf("rd_err[%0d]", m), 64'(rd_err[m]), 64'(e_err[m]));
            chk($sformatf("frozen[%0d]", m), 64'(frozen[m]), 64'(m_frz[m]));
            chk($sformatf("ovf[%0d]", m), 64'(ovf[m]), 64'(m_ovf[m]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int s, input int w);
        rd_en = 1'b1; rd_sel = 3'(s); rd_word = 1'(w);
        step();
        check_all();
        rd_en = 1'b0;
    endtask

    int seq[10] = '{0, 1, 1, 2, 3, 4, 5, 5, 6, 7};
    longint run_exp[4] = '{10, 8, 3, 2};

    initial begin
        pc = '0; read = 0; write = 0; halted = 0; clr = 0; snap = 0; rd_en = 0;
        ext = '0; rd_sel = '0; rd_word = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 10'(seq[i]); read = i < 3; write = i >= 3 && i < 5;
            step();
            check_all();
        end
        read = 0; write = 0; halted = 1;
        step();
        chk("halt_frozen", 64'(frozen[0]), 64'd1);
        for (int s = 0; s < 4; s++) begin
            rd(s, 0);
            chk($sformatf("halt_cnt%0d", s), 64'(rd_data[0]), run_exp[s]);
        end
        repeat (20) begin
            pc = 10'($urandom); read = 1'($urandom); write = 1'($urandom); ext = 2'($urandom);
            step();
            check_all();
        end
        snap = 1; step(); snap = 0;
        for (int s = 0; s < 4; s++) begin
            rd(s, 0);
            chk($sformatf("hold_cnt%0d", s), 64'(rd_data[0]), run_exp[s]);
        end
        clr = 1; step(); clr = 0;
        chk("clr_beats_halt", 64'(frozen[0]), 64'd0);
        check_all();
        step();
        chk("halt_after_clr", 64'(frozen[0]), 64'd1);
        rd(0, 0);
        chk("cycles_after_clr", 64'(rd_data[0]), 64'd0);
        halted = 0; read = 0; write = 0; ext = 2'b00;
        clr = 1; step(); clr = 0;
        ext = 2'b01;
        repeat (260) step();
        ext = 2'b00;
        snap = 1; step(); snap = 0;
        rd(4, 0);
        chk("ext0_32b", 64'(rd_data[0]), 64'd260);
        chk("ext0_wrap", 64'(rd_data[1]), 64'd4);
        chk("ext0_sat", 64'(rd_data[2]), 64'd255);
        chk("ovf4_wrap", 64'(ovf[1][4]), 64'd1);
        chk("ovf4_sat", 64'(ovf[2][4]), 64'd1);
        chk("ovf4_32b", 64'(ovf[0][4]), 64'd0);
        rd(6, 0);
        chk("sel_err", 64'(rd_err[0]), 64'd1);
        chk("sel_err_data", 64'(rd_data[0]), 64'd0);
        chk("sel_err_valid", 64'(rd_valid[0]), 64'd1);
        rd(1, 1);
        chk("word_err", 64'(rd_err[1]), 64'd1);
        chk("word_err_data", 64'(rd_data[1]), 64'd0);
        chk("word_ok_32b", 64'(rd_err[0]), 64'd0);
        repeat (400) begin
            pc = 10'($urandom_range(0, 3)); read = 1'($urandom); write = 1'($urandom); ext = 2'($urandom);
            halted = $urandom_range(0, 19) == 0; clr = $urandom_range(0, 29) == 0;
            snap = $urandom_range(0, 7) == 0; rd_en = 1'($urandom);
            rd_sel = 3'($urandom_range(0, 7)); rd_word = 1'($urandom);
            step();
            check_all();
        end
        pc = '0; read = 0; write = 0; ext = '0; halted = 0; snap = 0; rd_en = 0;
        clr = 1; step(); clr = 0;
        repeat (70000) step();
        snap = 1; step(); snap = 0;
        repeat (5) step();
        rd(0, 0);
        chk("big_word0", 64'(rd_data[0]), 64'h1170);
        rd(0, 1);
        chk("big_word1", 64'(rd_data[0]), 64'h0001);
        rd_en = 1; rd_sel = 3'd0; rd_word = 0;
        step();
        chk("pending_valid", 64'(rd_valid[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(rd_valid[0]), 64'd0);
        chk("rst_data", 64'(rd_data[0]), 64'd0);
        check_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Synthesizable hardware performance monitor that sits beside `cpu` and snoops its `pc`, `read`, `write` and `halted` signals.
- Counts cycles, retired instructions, memory reads, memory writes and NUM_EXT external events.
- Freezes on halt. Holds a snapshot shadow so multi-word counters read out atomically.
- Its read port is driven by a debug/UART bridge or by the bench, so these statistics no longer depend on bench-side bookkeeping.

Parameters:
- PC_WIDTH, 10, width of the snooped program counter
- DATA_WIDTH, 16, readout word width
- CNT_WIDTH, 32, width of each counter; any value >= 1
- NUM_EXT, 2, number of external event inputs (0 allowed)
- SATURATE, 0, 0 = wrap on overflow, 1 = hold at all-ones
- Derived: NUM_CNT = 4+NUM_EXT; WORDS = ceil(CNT_WIDTH/DATA_WIDTH); SEL_W = clog2(NUM_CNT); WRD_W = max(1, clog2(WORDS))

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pc  in  PC_WIDTH  cpu program counter
- read  in  1  cpu memory read strobe
- write  in  1  cpu memory write strobe
- halted  in  1  cpu halted flag
- ext_evt  in  max(1,NUM_EXT)  external event strobes, 1 count per cycle high
- clr  in  1  synchronous clear pulse
- snap  in  1  snapshot request pulse
- rd_en  in  1  readout request
- rd_sel  in  SEL_W  counter index: 0 cycles, 1 instructions, 2 reads, 3 writes, 4+k ext_evt[k]
- rd_word  in  WRD_W  word index, 0 = least significant
- rd_data  out  DATA_WIDTH  shadow word
- rd_valid  out  1  rd_data valid
- rd_err  out  1  out-of-range select or word
- frozen  out  1  counting stopped by halt
- ovf  out  NUM_CNT  sticky per-counter overflow

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters, shadows, ovf, frozen, rd_data, rd_valid and rd_err go to 0.
  - pc_prev goes to all-ones.
  - Counting starts on the first rising edge after reset deasserts.
- Each edge with frozen=0 and halted=0 sampled:
  - cycles += 1.
  - reads += read.
  - writes += write.
  - ext[k] += ext_evt[k].
  - If pc != pc_prev: instructions += 1 and pc_prev <= pc. The first pc after reset or clr therefore counts as one instruction.
- Halt:
  - First edge with halted=1 and frozen=0: frozen <= 1, every shadow <= its current counter value, and no counter increments on that edge.
  - While frozen=1, counters hold regardless of any input.
  - frozen is cleared only by reset or clr.
- Overflow:
  - An increment from all-ones sets ovf[i]=1 (sticky).
  - SATURATE=0: the counter wraps to 0.
  - SATURATE=1: the counter stays all-ones and later increments are ignored.
- clr (synchronous):
  - Counters, ovf and frozen go to 0; pc_prev goes to all-ones.
  - Shadows are untouched.
  - clr beats halt, snap and increments on the same edge. A halt sampled with clr is ignored; it is seen again on the next edge.
- snap:
  - Every shadow <= the counter value before that edge's increment.
  - With frozen=1 the counters are static, so snap recopies the same values.
- Readout:
  - Latency is 1 cycle: rd_en sampled at edge N gives rd_valid=1 after edge N, with rd_data and rd_err valid; rd_valid=0 otherwise.
  - rd_data = shadow[rd_sel] bits [rd_word*DATA_WIDTH +: DATA_WIDTH], zero-extended above CNT_WIDTH.
  - If rd_sel >= NUM_CNT or rd_word >= WORDS: rd_data=0 and rd_err=1, with rd_valid still 1.
  - rd_data holds its last value while rd_valid=0.
  - Readout reads only shadows and never perturbs counting. A snap and a rd_en on the same edge return the old shadow.
- Reset asserted mid-operation aborts any pending readout: rd_valid drops immediately.

Test Plan:
- Run 10 cycles, halt: release reset, pc steps 0,1,1,2,3,4,5,5,6,7 with read high 3 cycles and write high 2, then halted=1 → frozen=1 one edge later; shadows read cycles=10, instructions=8, reads=3, writes=2.
- Frozen hold: after the halt scenario, toggle pc/read/write/ext_evt for 20 cycles, then snap → all shadow values unchanged.
- Wrap vs saturate: CNT_WIDTH=8, hold ext_evt[0]=1 for 260 cycles, then snap. SATURATE=0 → ext0=4, ovf[4]=1. SATURATE=1 → ext0=255, ovf[4]=1.
- Multi-word atomic read: CNT_WIDTH=32, DATA_WIDTH=16, run 70000 cycles, snap, keep running, read word 0 then word 1 → 70000 = 0x0001_1170, so word 0 = 0x1170 and word 1 = 0x0001.
- Readout errors: rd_sel=NUM_CNT → rd_err=1, rd_data=0, rd_valid=1 one cycle later. Same for rd_word=WORDS.
- clr vs halt: clr and halted both high on one edge → counters=0, frozen stays 0; next edge (halted still 1) → frozen=1 with cycles=0. Asserting reset mid-count → all outputs 0 asynchronously.
